// File: rtl/zxuno_clken_gen.sv
// zxuno_clken_gen: log2-ratio clock-enable generator whose ratio changes are aligned to master-counter wrap
module zxuno_clken_gen #(
  parameter int CNT_W = 4,
  parameter int NCH = 3,
  parameter int DSEL_W = 3,
  parameter int RESET_DIV = 1
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic resync,
  input  logic [NCH*DSEL_W-1:0] ch_div,
  input  logic [NCH-1:0] ch_hold,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] clk_lvl,
  output logic [NCH*DSEL_W-1:0] div_active,
  output logic [NCH-1:0] upd
);
  localparam int W1 = CNT_W + 1;
  logic [CNT_W-1:0] divs;
  logic wrap;
  assign wrap = &divs;
  // free-running master counter; resync restarts it so every channel realigns to zero
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) divs <= '0;
    else divs <= resync ? '0 : divs + 1'b1;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DSEL_W-1:0] req, act_q;
    logic [W1-1:0] mask;
    logic hit, lvl, ce_q, lvl_q, upd_q;
    // mask covers the low d counter bits; its top bit is the square-wave source
    always_comb begin
      req = ch_div[i*DSEL_W +: DSEL_W] > DSEL_W'(CNT_W) ? DSEL_W'(CNT_W) : ch_div[i*DSEL_W +: DSEL_W];
      mask = (W1'(1) << act_q) - W1'(1);
      hit = ({1'b0, divs} & mask) == mask;
      lvl = |({1'b0, divs} & (mask ^ (mask >> 1)));
    end
    // per-channel enable, level and ratio register; new ratio only takes effect at wrap or resync
    always_ff @(posedge sysclk or negedge rst_n)
      if (!rst_n) begin
        act_q <= DSEL_W'(RESET_DIV);
        ce_q <= 1'b0;
        lvl_q <= 1'b0;
        upd_q <= 1'b0;
      end else begin
        ce_q <= hit & ~ch_hold[i] & ~resync;
        lvl_q <= lvl & ~resync;
        upd_q <= (wrap | resync) && req != act_q;
        if (wrap | resync) act_q <= req;
      end
    assign ce[i] = ce_q;
    assign clk_lvl[i] = lvl_q;
    assign upd[i] = upd_q;
    assign div_active[i*DSEL_W +: DSEL_W] = act_q;
  end
endmodule

// File: tb/tb_zxuno_clken_gen.sv
// tb_zxuno_clken_gen: random and directed checks of the clock-enable generator against an arithmetic model
module tb_zxuno_clken_gen;
  logic sysclk = 0, rst_n = 1, resync = 0;
  logic [8:0] ch_div = 9'o111;
  logic [2:0] ch_hold = 0;
  logic [2:0] ce, clk_lvl, upd;
  logic [8:0] div_active;
  int vectors = 0, errors = 0;
  int cnt = 0;
  int act[3] = '{1, 1, 1};
  int m_p, m_req;
  logic [2:0] e_ce = 0, e_lvl = 0, e_upd = 0;
  logic [8:0] e_div;

  zxuno_clken_gen dut (.sysclk(sysclk), .rst_n(rst_n), .resync(resync), .ch_div(ch_div),
    .ch_hold(ch_hold), .ce(ce), .clk_lvl(clk_lvl), .div_active(div_active), .upd(upd));

  always #5 sysclk = ~sysclk;

  // reference: channel with log2 ratio d pulses when (count+1) is a multiple of 2**d
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0;
      foreach (act[i]) act[i] = 1;
      e_ce = 0; e_lvl = 0; e_upd = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_p = 1 << act[i];
        e_ce[i] = ((cnt + 1) % m_p == 0) && !ch_hold[i] && !resync;
        e_lvl[i] = resync ? 1'b0 : (act[i] == 0 ? 1'b0 : ((cnt / (m_p / 2)) % 2 == 1));
        m_req = (ch_div >> (3 * i)) & 7;
        if (m_req > 4) m_req = 4;
        e_upd[i] = (cnt == 15 || resync) && m_req != act[i];
        if (cnt == 15 || resync) act[i] = m_req;
      end
      cnt = resync ? 0 : (cnt + 1) % 16;
    end
  end

  assign e_div = {3'(act[2]), 3'(act[1]), 3'(act[0])};

  // every-cycle comparison against the model
  always @(negedge sysclk) begin
    vectors++;
    if (ce !== e_ce) begin errors++; $display("FAIL model_ce t=%0t got %b exp %b", $time, ce, e_ce); end
    if (clk_lvl !== e_lvl) begin errors++; $display("FAIL model_lvl t=%0t got %b exp %b", $time, clk_lvl, e_lvl); end
    if (upd !== e_upd) begin errors++; $display("FAIL model_upd t=%0t got %b exp %b", $time, upd, e_upd); end
    if (div_active !== e_div) begin errors++; $display("FAIL model_div t=%0t got %o exp %o", $time, div_active, e_div); end
  end

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge sysclk);
    chk("rst_ce", 9'(ce), 0);
    chk("rst_lvl", 9'(clk_lvl), 0);
    chk("rst_div", div_active, 9'o111);
    #2 rst_n = 1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge sysclk);
      if (k == 1) chk("ce_e1", 9'(ce), 0);
      if (k == 2) chk("ce_e2", 9'(ce), 9'b111);
      if (k == 2) chk("lvl_e2", 9'(clk_lvl), 9'b111);
      if (k == 4) ch_div = {3'd7, 3'd1, 3'd2};
      if (k == 15) chk("div_pending", div_active, 9'o111);
      if (k == 16) chk("upd_wrap", 9'(upd), 9'b101);
      if (k == 16) chk("div_clamped", div_active, 9'o412);
      if (k == 17) chk("upd_once", 9'(upd), 0);
      if (k == 18) chk("ce0_e18", 9'(ce[0]), 0);
      if (k == 20) begin chk("ce0_e20", 9'(ce[0]), 1); ch_div = {3'd7, 3'd0, 3'd2}; end
      if (k == 31) chk("ce2_e31", 9'(ce[2]), 0);
      if (k == 32) chk("ce2_e32", 9'(ce[2]), 1);
      if (k == 32) chk("upd1_e32", 9'(upd), 9'b010);
      if (k == 33) chk("ce1_d0", 9'(ce[1]), 1);
      if (k == 34) chk("lvl1_d0", 9'(clk_lvl[1]), 0);
      if (k == 36) ch_div = {3'd7, 3'd0, 3'd3};
      if (k == 41) resync = 1;
      if (k == 42) begin
        resync = 0;
        chk("resync_ce", 9'(ce), 0);
        chk("resync_upd", 9'(upd), 9'b001);
        chk("resync_div", div_active, 9'o403);
      end
      if (k == 49) chk("ce0_e49", 9'(ce[0]), 0);
      if (k == 50) chk("ce0_e50", 9'(ce[0]), 1);
      if (k == 51) ch_hold = 3'b001;
      if (k == 58) chk("ce0_held", 9'(ce[0]), 0);
      if (k == 61) ch_hold = 0;
      if (k == 66) chk("ce0_after_hold", 9'(ce[0]), 1);
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge sysclk);
      if ($urandom_range(0, 15) == 0) ch_div = 9'($urandom);
      ch_hold = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      resync = ($urandom_range(0, 40) == 0);
    end
    @(posedge sysclk);
    #2 rst_n = 0;
    #1;
    chk("async_ce", 9'(ce), 0);
    chk("async_lvl", 9'(clk_lvl), 0);
    chk("async_upd", 9'(upd), 0);
    chk("async_div", div_active, 9'o111);
    resync = 0; ch_hold = 0; ch_div = 9'o111;
    repeat (2) @(negedge sysclk);
    #2 rst_n = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sysclk);
      if (k == 1) chk("rerst_ce_e1", 9'(ce), 0);
      if (k == 2) chk("rerst_ce_e2", 9'(ce), 9'b111);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
